// File: rtl/alu_mc.sv
`default_nettype none
// ============================================================================
//  Module   : alu_mc
//  Purpose  : Registered, multi-cycle ALU for the EX stage. The low half of
//             the 4-bit op space keeps the legacy 3-bit encodings; the upper
//             half adds XOR, shifts, and iterative unsigned MULU and DIVU.
//             Single-cycle ops return one result per cycle. MULU and DIVU
//             occupy the unit for WIDTH cycles, and in_ready stays low while
//             they run.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   rising-edge clock
//    rst_n      in   asynchronous active-low reset
//    in_valid   in   operation request
//    in_ready   out  high when a request can be accepted (state IDLE)
//    op         in   4-bit operation code
//    x          in   operand A
//    y          in   operand B / shift amount / divisor
//    flush      in   abort in-flight op (or the op accepted this cycle)
//    out_valid  out  one-cycle pulse, result fields valid
//    result     out  main result (low product / quotient)
//    result_hi  out  high product / remainder, 0 for other ops
//    overflow   out  signed overflow, ADD/SUB only
//    zero       out  result == 0
//    div_zero   out  DIVU with y == 0
// ============================================================================
module alu_mc #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             flush,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             overflow,
    output logic             zero,
    output logic             div_zero
);

    localparam int         c_CNT_W   = SHW + 1;
    localparam logic [3:0] c_OP_ADDU = 4'b0000;
    localparam logic [3:0] c_OP_ADD  = 4'b0001;
    localparam logic [3:0] c_OP_OR   = 4'b0010;
    localparam logic [3:0] c_OP_AND  = 4'b0011;
    localparam logic [3:0] c_OP_SUBU = 4'b0100;
    localparam logic [3:0] c_OP_SUB  = 4'b0101;
    localparam logic [3:0] c_OP_SLTU = 4'b0110;
    localparam logic [3:0] c_OP_SLT  = 4'b0111;
    localparam logic [3:0] c_OP_XOR  = 4'b1000;
    localparam logic [3:0] c_OP_SLL  = 4'b1001;
    localparam logic [3:0] c_OP_SRL  = 4'b1010;
    localparam logic [3:0] c_OP_SRA  = 4'b1011;
    localparam logic [3:0] c_OP_MULU = 4'b1100;
    localparam logic [3:0] c_OP_DIVU = 4'b1101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_t;

    state_t               r_state;
    logic [c_CNT_W-1:0]   r_count;
    // Iteration datapath shared by MUL and DIV:
    //   MUL: r_hi = partial product high half, r_lo = multiplier shifting out
    //        and low product bits shifting in, r_opb = multiplicand
    //   DIV: r_hi = partial remainder, r_lo = dividend shifting out and
    //        quotient bits shifting in, r_opb = divisor
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;
    logic [WIDTH-1:0]     r_opb;

    logic                 r_out_valid;
    logic [WIDTH-1:0]     r_result;
    logic [WIDTH-1:0]     r_result_hi;
    logic                 r_overflow;
    logic                 r_zero;
    logic                 r_div_zero;

    // ------------------------------------------------------------------
    // Single-cycle ALU
    // ------------------------------------------------------------------
    logic                 w_is_sub;
    logic [WIDTH-1:0]     w_opb;
    logic [WIDTH:0]       w_addsub;
    logic                 w_ovf;
    logic [SHW-1:0]       w_sh;
    logic [WIDTH-1:0]     w_alu_res;
    logic                 w_alu_ovf;

    always_comb begin
        // SUBU/SUB/SLTU/SLT all share the x + ~y + 1 path
        w_is_sub  = (op[3:2] == 2'b01);
        w_opb     = w_is_sub ? ~y : y;
        w_addsub  = {1'b0, x} + {1'b0, w_opb} + {{WIDTH{1'b0}}, w_is_sub};
        w_ovf     = (x[WIDTH-1] == w_opb[WIDTH-1]) &&
                    (w_addsub[WIDTH-1] != x[WIDTH-1]);
        w_sh      = y[SHW-1:0];
        w_alu_res = '0;
        w_alu_ovf = 1'b0;
        case (op)
            c_OP_ADDU, c_OP_SUBU: w_alu_res = w_addsub[WIDTH-1:0];
            c_OP_ADD,  c_OP_SUB: begin
                w_alu_res = w_addsub[WIDTH-1:0];
                w_alu_ovf = w_ovf;
            end
            c_OP_OR:   w_alu_res = x | y;
            c_OP_AND:  w_alu_res = x & y;
            // Carry out of x + ~y + 1 is the inverse of the borrow
            c_OP_SLTU: w_alu_res = {{(WIDTH-1){1'b0}}, ~w_addsub[WIDTH]};
            c_OP_SLT:  w_alu_res = {{(WIDTH-1){1'b0}}, w_addsub[WIDTH-1] ^ w_ovf};
            c_OP_XOR:  w_alu_res = x ^ y;
            c_OP_SLL:  w_alu_res = x << w_sh;
            c_OP_SRL:  w_alu_res = x >> w_sh;
            c_OP_SRA:  w_alu_res = $unsigned($signed(x) >>> w_sh);
            default:   w_alu_res = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // One iteration step of MUL (radix-2 shift-add) or DIV (restoring)
    // ------------------------------------------------------------------
    logic [WIDTH:0]       w_mul_sum;
    logic [WIDTH:0]       w_div_sh;
    logic [WIDTH:0]       w_div_trial;
    logic [WIDTH-1:0]     w_step_hi;
    logic [WIDTH-1:0]     w_step_lo;

    always_comb begin
        w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opb} : '0);
        w_div_sh    = {r_hi, r_lo[WIDTH-1]};
        w_div_trial = w_div_sh - {1'b0, r_opb};
        if (r_state == S_DIV) begin
            // A non-negative trial difference means the divisor fits
            if (!w_div_trial[WIDTH]) begin
                w_step_hi = w_div_trial[WIDTH-1:0];
                w_step_lo = {r_lo[WIDTH-2:0], 1'b1};
            end else begin
                w_step_hi = w_div_sh[WIDTH-1:0];
                w_step_lo = {r_lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            // Shift the {carry, sum, multiplier} chain right by one
            w_step_hi = w_mul_sum[WIDTH:1];
            w_step_lo = {w_mul_sum[0], r_lo[WIDTH-1:1]};
        end
    end

    // ------------------------------------------------------------------
    // Control FSM and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_count     <= '0;
            r_hi        <= '0;
            r_lo        <= '0;
            r_opb       <= '0;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_result_hi <= '0;
            r_overflow  <= 1'b0;
            r_zero      <= 1'b1;
            r_div_zero  <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (in_valid && !flush) begin
                        if (op == c_OP_MULU) begin
                            r_hi    <= '0;
                            r_lo    <= y;
                            r_opb   <= x;
                            r_count <= c_CNT_W'(WIDTH);
                            r_state <= S_MUL;
                        end else if (op == c_OP_DIVU && y != '0) begin
                            r_hi    <= '0;
                            r_lo    <= x;
                            r_opb   <= y;
                            r_count <= c_CNT_W'(WIDTH);
                            r_state <= S_DIV;
                        end else if (op == c_OP_DIVU) begin
                            r_out_valid <= 1'b1;
                            r_result    <= '1;
                            r_result_hi <= x;
                            r_overflow  <= 1'b0;
                            r_zero      <= 1'b0;
                            r_div_zero  <= 1'b1;
                        end else begin
                            r_out_valid <= 1'b1;
                            r_result    <= w_alu_res;
                            r_result_hi <= '0;
                            r_overflow  <= w_alu_ovf;
                            r_zero      <= (w_alu_res == '0);
                            r_div_zero  <= 1'b0;
                        end
                    end
                end
                S_MUL, S_DIV: begin
                    if (flush) begin
                        // Abandon the iteration; output registers keep their value
                        r_state <= S_IDLE;
                        r_count <= '0;
                    end else begin
                        r_hi    <= w_step_hi;
                        r_lo    <= w_step_lo;
                        r_count <= r_count - c_CNT_W'(1);
                        // Last step: its result goes straight to the outputs
                        if (r_count == c_CNT_W'(1)) begin
                            r_state     <= S_IDLE;
                            r_out_valid <= 1'b1;
                            r_result    <= w_step_lo;
                            r_result_hi <= w_step_hi;
                            r_overflow  <= 1'b0;
                            r_zero      <= (w_step_lo == '0);
                            r_div_zero  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_count <= '0;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign result_hi = r_result_hi;
    assign overflow  = r_overflow;
    assign zero      = r_zero;
    assign div_zero  = r_div_zero;

endmodule
`default_nettype wire

// File: tb/tb_alu_mc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_mc
//  Purpose  : Self-checking bench for alu_mc (WIDTH=32). Directed cases plus
//             randomized ops compared against a plain-arithmetic reference.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_mc;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   op;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         flush;
    logic         out_valid;
    logic [W-1:0] result;
    logic [W-1:0] result_hi;
    logic         overflow;
    logic         zero;
    logic         div_zero;

    int n_cmp = 0;
    int n_err = 0;

    alu_mc #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .x         (x),
        .y         (y),
        .flush     (flush),
        .out_valid (out_valid),
        .result    (result),
        .result_hi (result_hi),
        .overflow  (overflow),
        .zero      (zero),
        .div_zero  (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: plain arithmetic straight from the op table
    task automatic model(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] r, output logic [W-1:0] rh,
                         output logic ov, output logic dz, output int lat);
        longint      sa, sb, s;
        logic [63:0] p;
        logic [4:0]  sh;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        sh  = b[4:0];
        r   = '0;
        rh  = '0;
        ov  = 1'b0;
        dz  = 1'b0;
        lat = 1;
        case (o)
            4'd0:  r = a + b;
            4'd1: begin
                s  = sa + sb;
                r  = W'(s);
                ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd2:  r = a | b;
            4'd3:  r = a & b;
            4'd4:  r = a - b;
            4'd5: begin
                s  = sa - sb;
                r  = W'(s);
                ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd6:  r = (a < b) ? 1 : 0;
            4'd7:  r = (sa < sb) ? 1 : 0;
            4'd8:  r = a ^ b;
            4'd9:  r = W'({32'd0, a} << sh);
            4'd10: r = a >> sh;
            4'd11: r = W'(sa >>> sh);
            4'd12: begin
                p   = {32'd0, a} * {32'd0, b};
                r   = p[31:0];
                rh  = p[63:32];
                lat = W + 1;
            end
            4'd13: begin
                if (b == 0) begin
                    r  = '1;
                    rh = a;
                    dz = 1'b1;
                end else begin
                    r   = a / b;
                    rh  = a % b;
                    lat = W + 1;
                end
            end
            default: r = '0;
        endcase
    endtask

    // Wait for in_ready, present one request for one edge, then scramble inputs
    task automatic issue(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        int g;
        g = 0;
        while (!in_ready && g < 100) begin
            @(posedge clk); #1;
            g++;
        end
        op = o; x = a; y = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        op = 4'($urandom); x = $urandom; y = $urandom;
    endtask

    task automatic do_op(input string tag, input logic [3:0] o, input logic [W-1:0] a,
                         input logic [W-1:0] b);
        logic [W-1:0] er, erh, held;
        logic         eov, edz;
        int           elat, lat, busy;
        model(o, a, b, er, erh, eov, edz, elat);
        issue(o, a, b);
        lat  = 1;
        busy = 0;
        while (!out_valid && lat < 100) begin
            if (!in_ready) busy++;
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_lat"},  64'(lat),  64'(elat));
        check({tag, "_busy"}, 64'(busy), 64'(elat - 1));
        check({tag, "_res"},  64'(result),    64'(er));
        check({tag, "_hi"},   64'(result_hi), 64'(erh));
        check({tag, "_flags"}, {61'd0, overflow, zero, div_zero},
              {61'd0, eov, (er == 0), edz});
        held = result;
        @(posedge clk); #1;
        check({tag, "_pulse"}, {63'd0, out_valid}, 64'd0);
        check({tag, "_hold"},  64'(result), 64'(held));
        // restore the sampling point that do_op callers expect
    endtask

    initial begin
        logic [W-1:0] held;
        logic [3:0]   ro;
        logic [W-1:0] ra, rb;
        int           pulses;

        rst_n = 1'b1; in_valid = 1'b0; flush = 1'b0; op = '0; x = '0; y = '0;

        // Reset state
        #3 rst_n = 1'b0;
        #1;
        check("rst_outs", {out_valid, overflow, zero, div_zero, result, result_hi},
              {4'b0010, 64'd0});
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1;

        // ADD overflow and ADDU without
        do_op("add_ovf", 4'd1, 32'h7FFF_FFFF, 32'd1);
        do_op("addu_ovf", 4'd0, 32'h7FFF_FFFF, 32'd1);
        do_op("add_tp", 4'd1, 32'h7FFF_FFFF, 32'd1);
        @(posedge clk); #1;

        // Back-to-back SUB / SLT / SLTU
        op = 4'd5; x = 32'd5; y = 32'd5; in_valid = 1'b1;
        @(posedge clk); #1;
        check("b2b_sub", {62'd0, out_valid, zero, result}, {62'd0, 2'b11, 32'd0});
        op = 4'd7; x = 32'hFFFF_FFFF; y = 32'd1;
        @(posedge clk); #1;
        check("b2b_sub_res", {63'd0, out_valid}, 64'd1);
        check("b2b_slt", 64'(result), 64'd1);
        op = 4'd6; x = 32'hFFFF_FFFF; y = 32'd1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("b2b_sltu", {62'd0, out_valid, zero, result}, {62'd0, 2'b11, 32'd0});
        @(posedge clk); #1;
        check("b2b_end", {63'd0, out_valid}, 64'd0);

        // Shifts
        do_op("sra", 4'd11, 32'h8000_0000, 32'h21);
        issue(4'd11, 32'h8000_0000, 32'h21);
        check("sra_tp", 64'(result), 64'hC000_0000);
        issue(4'd9, 32'd1, 32'd31);
        check("sll_tp", 64'(result), 64'h8000_0000);

        // Multi-cycle directed
        do_op("mulu_max", 4'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("mulu_tp", {result_hi, result}, 64'hFFFF_FFFE_0000_0001);
        do_op("divu", 4'd13, 32'd100, 32'd7);
        check("divu_tp", {result_hi, result}, {32'd2, 32'd14});
        do_op("divu_z", 4'd13, 32'd9, 32'd0);
        check("divu_z_tp", {62'd0, div_zero, zero, result_hi},
              {62'd0, 2'b10, 32'd9});
        do_op("reserved", 4'd14, 32'h1234, 32'h5678);
        do_op("reserved2", 4'd15, 32'hFFFF_FFFF, 32'd1);

        // Flush during MULU
        held = result;
        issue(4'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (9) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_ready", {63'd0, in_ready}, 64'd1);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) pulses++;
            @(posedge clk); #1;
        end
        check("flush_nopulse", 64'(pulses), 64'd0);
        check("flush_hold", 64'(result), 64'(held));
        do_op("after_flush", 4'd0, 32'd2, 32'd3);
        check("after_flush_tp", 64'(result), 64'd5);

        // Flush in IDLE together with accept
        op = 4'd0; x = 32'd1; y = 32'd1; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        check("idle_flush", {62'd0, out_valid, in_ready}, 64'd1);
        @(posedge clk); #1;
        check("idle_flush2", {63'd0, out_valid}, 64'd0);
        check("idle_flush_res", 64'(result), 64'd5);

        // Randomized ops
        for (int i = 0; i < 200; i++) begin
            ro = 4'($urandom_range(0, 15));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: ra = 32'h8000_0000;
                1: rb = 32'h7FFF_FFFF;
                2: rb = 32'd0;
                3: rb = 32'($urandom_range(1, 15));
                default: ;
            endcase
            do_op("rand", ro, ra, rb);
        end

        // Asynchronous reset mid-DIVU
        do_op("pre_rst", 4'd13, 32'd9, 32'd0);
        issue(4'd13, 32'd100, 32'd7);
        repeat (5) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_outs", {out_valid, overflow, zero, div_zero, result, result_hi},
              {4'b0010, 64'd0});
        check("rst_mid_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_op("after_rst", 4'd0, 32'd2, 32'd3);
        check("after_rst_tp", 64'(result), 64'd5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
